// File: rtl/ssd_scan_controller_pkg.sv
// Shared constants for the 7-segment scan controller.
// Holds the blank cathode and anode codes, the FSM state encodings, and
// a helper that turns a digit index into its active-low anode pattern.
package ssd_scan_controller_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    localparam logic [1:0] SCAN_BLANK = 2'd0;
    localparam logic [1:0] SCAN_SHOW  = 2'd1;
    localparam logic [1:0] MODE_HOLD  = 2'd2;

    // Active-low one-hot anode select for digit idx.
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        an_select = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/ssd_scan_controller_if.sv
// Bus between output_encoder, the scan controller and the board pins.
// Signals:
//   C3..C0   segment codes from output_encoder (active-low, 7'h7F = blank)
//   ovf_in   overflow flag from output_encoder
//   M        mode control
//   seg, an  shared cathodes and active-low anodes (registered)
//   led_ovf  blinking overflow LED (registered)
//   state    controller FSM state, exposed for debug
// There is no valid/ready handshake: every input is level-sampled on each
// rising clock edge, and every output is a register updated on that edge.
interface ssd_scan_controller_if;
    import ssd_scan_controller_pkg::*;

    logic [6:0] C3;
    logic [6:0] C2;
    logic [6:0] C1;
    logic [6:0] C0;
    logic       ovf_in;
    logic       M;
    logic [6:0] seg;
    logic [3:0] an;
    logic       led_ovf;
    logic [1:0] state;

    modport master (
        output C3, C2, C1, C0, ovf_in, M,
        input  seg, an, led_ovf, state
    );

    modport slave (
        input  C3, C2, C1, C0, ovf_in, M,
        output seg, an, led_ovf, state
    );

endinterface

// File: rtl/ssd_scan_controller_slot_timer.sv
// Digit-slot prescaler.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr       synchronous clear; wins over counting and suppresses tick
//   cnt       position inside the slot, 0..PRESCALE-1
//   tick      high during the last cycle of a slot (the wrap cycle)
module slot_timer
    import ssd_scan_controller_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int CW       = $clog2(PRESCALE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          tick
);

    logic at_end;

    assign at_end = (cnt == CW'(PRESCALE - 1));
    assign tick   = at_end && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ssd_scan_controller.sv
// Time-multiplexes four active-low 7-segment codes onto one cathode bus.
// Each slot starts with BLANK_CYC cycles of all anodes off (anti-ghosting),
// then shows the digit latched at slot start. A change on M blanks the
// display for HOLD_SLOTS slots and restarts the scan at digit 0. The
// overflow LED blinks with a half-period of BLINK_SLOTS slots.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   bus       slave side of ssd_scan_controller_if (codes, M, ovf_in in;
//             seg, an, led_ovf, state out)
module ssd_scan_controller
    import ssd_scan_controller_pkg::*;
#(
    parameter int PRESCALE    = 50000,
    parameter int BLANK_CYC   = 4,
    parameter int HOLD_SLOTS  = 8,
    parameter int BLINK_SLOTS = 64
) (
    input logic                  clk,
    input logic                  rst,
    ssd_scan_controller_if.slave bus
);

    localparam int CW = $clog2(PRESCALE);
    localparam int HW = (HOLD_SLOTS > 1) ? $clog2(HOLD_SLOTS) : 1;
    localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

    logic [CW-1:0] cnt;
    logic          tick;
    logic          m_q;
    logic          mode_chg;
    logic [1:0]    state, nxt_state;
    logic [1:0]    idx, nxt_idx;
    logic [6:0]    code_q, nxt_code, code_sel;
    logic [HW-1:0] hold_cnt, nxt_hold;
    logic          ovf_q;
    logic          blink_ph, nxt_ph;
    logic [BW-1:0] blink_cnt, nxt_bcnt;
    logic [6:0]    seg_r;
    logic [3:0]    an_r;
    logic          led_r;

    assign mode_chg = (bus.M != m_q);

    // A mode change clears the slot counter so the hold is whole slots.
    slot_timer #(
        .PRESCALE (PRESCALE),
        .CW       (CW)
    ) u_slot_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (mode_chg),
        .cnt  (cnt),
        .tick (tick)
    );

    always_comb begin
        case (idx)
            2'd0:    code_sel = bus.C0;
            2'd1:    code_sel = bus.C1;
            2'd2:    code_sel = bus.C2;
            default: code_sel = bus.C3;
        endcase
    end

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_code  = code_q;
        nxt_hold  = hold_cnt;
        if (mode_chg) begin
            nxt_state = MODE_HOLD;
            nxt_idx   = 2'd0;
            nxt_hold  = '0;
        end else begin
            case (state)
                SCAN_BLANK: begin
                    // Latching only at slot start keeps a digit from tearing.
                    if (cnt == '0) begin
                        nxt_code = code_sel;
                    end
                    if (cnt == CW'(BLANK_CYC - 1)) begin
                        nxt_state = SCAN_SHOW;
                    end
                end
                SCAN_SHOW: begin
                    if (tick) begin
                        nxt_idx   = idx + 2'd1;
                        nxt_state = SCAN_BLANK;
                    end
                end
                MODE_HOLD: begin
                    if (tick) begin
                        if (hold_cnt == HW'(HOLD_SLOTS - 1)) begin
                            nxt_state = SCAN_BLANK;
                            nxt_idx   = 2'd0;
                            nxt_hold  = '0;
                        end else begin
                            nxt_hold = hold_cnt + HW'(1);
                        end
                    end
                end
                default: nxt_state = SCAN_BLANK;
            endcase
        end
    end

    always_comb begin
        nxt_ph   = blink_ph;
        nxt_bcnt = blink_cnt;
        if (bus.ovf_in && !ovf_q) begin
            nxt_ph   = 1'b1;
            nxt_bcnt = '0;
        end else if (bus.ovf_in && tick) begin
            if (blink_cnt == BW'(BLINK_SLOTS - 1)) begin
                nxt_bcnt = '0;
                nxt_ph   = ~blink_ph;
            end else begin
                nxt_bcnt = blink_cnt + BW'(1);
            end
        end
    end

    // Outputs are registered from the next-state values so they line up
    // with the state register: seg/an/led always describe the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN_BLANK;
            idx       <= 2'd0;
            code_q    <= SEG_BLANK;
            hold_cnt  <= '0;
            m_q       <= bus.M;
            ovf_q     <= 1'b0;
            blink_ph  <= 1'b1;
            blink_cnt <= '0;
            seg_r     <= SEG_BLANK;
            an_r      <= AN_OFF;
            led_r     <= 1'b0;
        end else begin
            state     <= nxt_state;
            idx       <= nxt_idx;
            code_q    <= nxt_code;
            hold_cnt  <= nxt_hold;
            m_q       <= bus.M;
            ovf_q     <= bus.ovf_in;
            blink_ph  <= nxt_ph;
            blink_cnt <= nxt_bcnt;
            seg_r     <= (nxt_state == SCAN_SHOW) ? nxt_code : SEG_BLANK;
            an_r      <= ((nxt_state == SCAN_SHOW) && (nxt_code != SEG_BLANK))
                         ? an_select(nxt_idx) : AN_OFF;
            led_r     <= bus.ovf_in && nxt_ph && (nxt_state != MODE_HOLD);
        end
    end

    assign bus.seg     = seg_r;
    assign bus.an      = an_r;
    assign bus.led_ovf = led_r;
    assign bus.state   = state;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Bench for ssd_scan_controller with PRESCALE=8, BLANK_CYC=2, HOLD_SLOTS=2,
// BLINK_SLOTS=3. A cycle-level model of the display behaviour predicts the
// outputs; a compare process checks them every cycle, and directed steps add
// hand-computed literal expectations.
module tb_ssd_scan_controller;

    localparam int P  = 8;
    localparam int BC = 2;
    localparam int HS = 2;
    localparam int BS = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ssd_scan_controller_if bus();

    ssd_scan_controller #(
        .PRESCALE    (P),
        .BLANK_CYC   (BC),
        .HOLD_SLOTS  (HS),
        .BLINK_SLOTS (BS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic checking = 1'b0;
    int cur_e = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int         m_pos = 0;
    int         m_digit = 0;
    int         m_hold = 0;
    int         m_bslots = 0;
    logic       m_mprev = 1'b0;
    logic       m_ovfprev = 1'b0;
    logic       m_ph = 1'b1;
    logic [6:0] m_shown = 7'h7F;
    logic [11:0] exp_q[$];

    function automatic logic [6:0] code_of(input int d);
        case (d)
            0:       return bus.C0;
            1:       return bus.C1;
            2:       return bus.C2;
            default: return bus.C3;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int d);
        case (d)
            0:       return 4'hE;
            1:       return 4'hD;
            2:       return 4'hB;
            default: return 4'h7;
        endcase
    endfunction

    task automatic model_reset();
        m_pos = 0; m_digit = 0; m_hold = 0; m_bslots = 0;
        m_mprev = bus.M; m_ovfprev = 1'b0; m_ph = 1'b1; m_shown = 7'h7F;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic mchg;
        logic m_tick;
        mchg = (bus.M != m_mprev);
        m_mprev = bus.M;
        m_tick = !mchg && (m_pos == P - 1);
        if (bus.ovf_in && !m_ovfprev) begin
            m_ph = 1'b1;
            m_bslots = 0;
        end else if (bus.ovf_in && m_tick) begin
            m_bslots++;
            if (m_bslots == BS) begin
                m_bslots = 0;
                m_ph = !m_ph;
            end
        end
        m_ovfprev = bus.ovf_in;
        if (mchg) begin
            m_hold = HS * P;
            m_pos = 0;
            m_digit = 0;
        end else begin
            if (m_hold == 0 && m_pos == 0) m_shown = code_of(m_digit);
            if (m_hold > 0) m_hold--;
            else if (m_tick) m_digit = (m_digit + 1) % 4;
            m_pos = (m_pos + 1) % P;
        end
    endtask

    task automatic model_push();
        logic       show;
        logic [6:0] s;
        logic [3:0] a;
        logic       l;
        show = (m_hold == 0) && (m_pos >= BC);
        s = show ? m_shown : 7'h7F;
        a = (show && m_shown != 7'h7F) ? an_of(m_digit) : 4'hF;
        l = m_ovfprev && m_ph && (m_hold == 0);
        exp_q.push_back({s, a, l});
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
            model_push();
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                if (checking) begin
                    total++;
                    bad++;
                    $display("FAIL sb_queue: got empty expected entry at %0t", $time);
                end
            end else begin
                e = exp_q.pop_front();
                if (checking) begin
                    chk("sb_seg", 32'(bus.seg), 32'(e[11:5]));
                    chk("sb_an", 32'(bus.an), 32'(e[4:1]));
                    chk("sb_led", 32'(bus.led_ovf), 32'(e[0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_codes(input logic [6:0] c0, input logic [6:0] c1,
                             input logic [6:0] c2, input logic [6:0] c3);
        bus.C0 = c0; bus.C1 = c1; bus.C2 = c2; bus.C3 = c3;
    endtask

    task automatic to_edge(input int target);
        while (cur_e < target) begin
            @(posedge clk);
            cur_e++;
        end
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        checking = 1'b1;
        #1;
        chk("rst_seg", 32'(bus.seg), 32'h7F);
        chk("rst_an", 32'(bus.an), 32'hF);
        chk("rst_led", 32'(bus.led_ovf), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cur_e = 0;
    endtask

    task automatic lit(input int e, input string name, input logic [6:0] s, input logic [3:0] a);
        to_edge(e);
        @(negedge clk);
        chk({name, "_seg"}, 32'(bus.seg), 32'(s));
        chk({name, "_an"}, 32'(bus.an), 32'(a));
    endtask

    task automatic lit_an(input int e, input string name, input logic [3:0] a);
        to_edge(e);
        @(negedge clk);
        chk(name, 32'(bus.an), 32'(a));
    endtask

    task automatic lit_led(input int e, input string name, input logic l);
        to_edge(e);
        @(negedge clk);
        chk(name, 32'(bus.led_ovf), 32'(l));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_codes(7'h40, 7'h79, 7'h24, 7'h30);
        bus.M = 1'b0;
        bus.ovf_in = 1'b0;

        // Basic scan of four digits and repeat.
        do_reset();
        lit(1, "t2_blank", 7'h7F, 4'hF);
        lit(2, "t2_d0", 7'h40, 4'hE);
        lit(9, "t2_gap", 7'h7F, 4'hF);
        lit(10, "t2_d1", 7'h79, 4'hD);
        lit(18, "t2_d2", 7'h24, 4'hB);
        lit(26, "t2_d3", 7'h30, 4'h7);
        lit(34, "t2_rep", 7'h40, 4'hE);

        // No tearing: C1 changes at cycle 4 of slot 1.
        do_reset();
        to_edge(12);
        #1 bus.C1 = 7'h12;
        lit(14, "t3_keep", 7'h79, 4'hD);
        lit(42, "t3_new", 7'h12, 4'hD);

        // Blank digits 2 and 3 keep anodes off.
        set_codes(7'h40, 7'h79, 7'h7F, 7'h7F);
        do_reset();
        lit(2, "t4_d0", 7'h40, 4'hE);
        lit(10, "t4_d1", 7'h79, 4'hD);
        lit(18, "t4_d2", 7'h7F, 4'hF);
        lit(26, "t4_d3", 7'h7F, 4'hF);

        // Mode change blanks for two slots; second toggle restarts the hold.
        set_codes(7'h40, 7'h79, 7'h24, 7'h30);
        bus.ovf_in = 1'b1;
        do_reset();
        to_edge(4);
        #1 bus.M = 1'b1;
        lit(5, "t5_hold_start", 7'h7F, 4'hF);
        lit_led(6, "t5_hold_led", 1'b0);
        lit_an(20, "t5_hold_end", 4'hF);
        lit(23, "t5_resume", 7'h40, 4'hE);
        do_reset();
        to_edge(4);
        #1 bus.M = 1'b0;
        to_edge(12);
        #1 bus.M = 1'b1;
        lit_an(23, "t5_ext_a", 4'hF);
        lit_an(28, "t5_ext_b", 4'hF);
        lit_an(30, "t5_ext_c", 4'hF);
        lit(31, "t5_ext_resume", 7'h40, 4'hE);

        // Overflow LED blinking.
        bus.ovf_in = 1'b0;
        do_reset();
        lit_led(3, "t6_off", 1'b0);
        #1 bus.ovf_in = 1'b1;
        lit_led(4, "t6_rise", 1'b1);
        lit_led(23, "t6_on_end", 1'b1);
        lit_led(24, "t6_toggle0", 1'b0);
        lit_led(47, "t6_off_end", 1'b0);
        lit_led(48, "t6_toggle1", 1'b1);
        lit_led(50, "t6_on_again", 1'b1);
        #1 bus.ovf_in = 1'b0;
        lit_led(51, "t6_fall", 1'b0);
        #1 bus.ovf_in = 1'b1;
        lit_led(52, "t6_rerise", 1'b1);
        to_edge(54);

        // Reset in the middle of a lit digit with the LED on.
        do_reset();
        lit(2, "t1_restart", 7'h40, 4'hE);
        to_edge(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
